// File: rtl/picobello_soc_ctrl.sv
// picobello_soc_ctrl: register-bus slave for SoC-level control.
// Provides four scratch registers, per-tile clock enables, per-tile
// reset pulses driven by a shared down-counter, and a watchdog whose
// expiry is reported as a level interrupt. Every access is answered
// with exactly one wait state by a two-state response FSM.
module picobello_soc_ctrl #(
    parameter int unsigned NumTiles  = 16,
    parameter int unsigned RstCycles = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                reg_valid_i,
    input  logic                reg_write_i,
    input  logic [31:0]         reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    input  logic [3:0]          reg_wstrb_i,
    output logic                reg_ready_o,
    output logic [31:0]         reg_rdata_o,
    output logic                reg_error_o,
    output logic [NumTiles-1:0] tile_clk_en_o,
    output logic [NumTiles-1:0] tile_rst_o,
    output logic                wdt_irq_o
);

    localparam int unsigned CntW = $clog2(RstCycles + 1);

    // Word indices (byte offset >> 2)
    localparam logic [3:0] WClkEn   = 4'd4;
    localparam logic [3:0] WTileRst = 4'd5;
    localparam logic [3:0] WCtrl    = 4'd6;
    localparam logic [3:0] WLoad    = 4'd7;
    localparam logic [3:0] WCount   = 4'd8;
    localparam logic [3:0] WStatus  = 4'd9;

    typedef enum logic {
        StIdle = 1'b0,
        StAck  = 1'b1
    } state_e;

    state_e               state_q;
    logic                 ready_q;
    logic                 error_q;
    logic [31:0]          rdata_q;

    logic [3:0][31:0]     scratch_q, scratch_d;
    logic [NumTiles-1:0]  clk_en_q, clk_en_d;
    logic [NumTiles-1:0]  rst_active_q, rst_active_d;
    logic [CntW-1:0]      rst_cnt_q, rst_cnt_d;
    logic                 wdt_en_q, wdt_en_d;
    logic                 wdt_expired_q, wdt_expired_d;
    logic [31:0]          wdt_load_q, wdt_load_d;
    logic [31:0]          wdt_count_q, wdt_count_d;

    // Address decode: only the low six address bits select a register
    logic [5:0]  offset;
    logic [3:0]  word;
    logic        acc_err;
    logic        req;
    logic        wr_en;
    logic [31:0] wmask;
    logic [31:0] wdata_m;
    logic        unused_addr;

    assign offset      = reg_addr_i[5:0];
    assign word        = offset[5:2];
    assign unused_addr = ^reg_addr_i[31:6];
    assign acc_err     = (offset[1:0] != 2'b00) || (offset > 6'h24)
                         || (reg_write_i && (word == WCount));
    assign req         = (state_q == StIdle) && reg_valid_i;
    assign wr_en       = req && reg_write_i && !acc_err;
    assign wmask       = {{8{reg_wstrb_i[3]}}, {8{reg_wstrb_i[2]}},
                          {8{reg_wstrb_i[1]}}, {8{reg_wstrb_i[0]}}};
    assign wdata_m     = reg_wdata_i & wmask;

    // Watchdog control strobes; only byte 0 of CTRL/STATUS carries fields
    logic ctrl_wr;
    logic wdt_kick;
    logic wdt_reload;
    logic wdt_expire;
    logic wdt_clr;

    assign ctrl_wr    = wr_en && (word == WCtrl) && reg_wstrb_i[0];
    assign wdt_kick   = ctrl_wr && reg_wdata_i[1];
    assign wdt_reload = wdt_kick || (ctrl_wr && reg_wdata_i[0] && !wdt_en_q);
    assign wdt_expire = wdt_en_q && (wdt_count_q == 32'd0) && !wdt_reload;
    assign wdt_clr    = wr_en && (word == WStatus) && reg_wstrb_i[0] && reg_wdata_i[0];

    // Scratch, clock-enable and load registers: bytewise strobed writes
    always_comb begin
        scratch_d  = scratch_q;
        clk_en_d   = clk_en_q;
        wdt_load_d = wdt_load_q;
        for (int i = 0; i < 4; i++) begin
            if (wr_en && (word == 4'(i))) begin
                scratch_d[i] = (scratch_q[i] & ~wmask) | wdata_m;
            end
        end
        if (wr_en && (word == WClkEn)) begin
            clk_en_d = (clk_en_q & ~wmask[NumTiles-1:0]) | wdata_m[NumTiles-1:0];
        end
        if (wr_en && (word == WLoad)) begin
            wdt_load_d = (wdt_load_q & ~wmask) | wdata_m;
        end
    end

    // Tile reset pulse: a non-zero write extends the active set and restarts the shared count
    logic [NumTiles-1:0] rst_req;
    assign rst_req = (wr_en && (word == WTileRst)) ? wdata_m[NumTiles-1:0] : '0;

    always_comb begin
        rst_active_d = rst_active_q;
        rst_cnt_d    = rst_cnt_q;
        if (rst_req != '0) begin
            rst_active_d = rst_active_q | rst_req;
            rst_cnt_d    = CntW'(RstCycles);
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - CntW'(1);
            if (rst_cnt_q == CntW'(1)) begin
                rst_active_d = '0;
            end
        end
    end

    // Watchdog next state: reload beats expiry, expiry beats clear, expiry freezes the count
    always_comb begin
        wdt_en_d      = wdt_en_q;
        wdt_count_d   = wdt_count_q;
        wdt_expired_d = (wdt_expired_q && !wdt_clr) || wdt_expire;
        if (ctrl_wr) begin
            wdt_en_d = reg_wdata_i[0];
        end
        if (wdt_reload) begin
            wdt_count_d = wdt_load_q;
        end else if (wdt_en_q && !wdt_expired_q && (wdt_count_q != 32'd0)) begin
            wdt_count_d = wdt_count_q - 32'd1;
        end
    end

    // Read multiplexer; unimplemented bits and the KICK bit read as zero
    logic [31:0] rdata_mux;
    always_comb begin
        rdata_mux = '0;
        case (word)
            4'd0, 4'd1, 4'd2, 4'd3: rdata_mux = scratch_q[word[1:0]];
            WClkEn:                 rdata_mux[NumTiles-1:0] = clk_en_q;
            WTileRst:               rdata_mux[NumTiles-1:0] = rst_active_q;
            WCtrl:                  rdata_mux[0] = wdt_en_q;
            WLoad:                  rdata_mux = wdt_load_q;
            WCount:                 rdata_mux = wdt_count_q;
            WStatus:                rdata_mux[0] = wdt_expired_q;
            default:                rdata_mux = '0;
        endcase
    end

    // Response FSM: capture the access in IDLE, present it for one cycle in ACK
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (reg_valid_i) begin
                        state_q <= StAck;
                        ready_q <= 1'b1;
                        error_q <= acc_err;
                        rdata_q <= (acc_err || reg_write_i) ? 32'd0 : rdata_mux;
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    // Register file, tile reset and watchdog state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scratch_q     <= '0;
            clk_en_q      <= '1;
            rst_active_q  <= '0;
            rst_cnt_q     <= '0;
            wdt_en_q      <= 1'b0;
            wdt_expired_q <= 1'b0;
            wdt_load_q    <= '0;
            wdt_count_q   <= '0;
        end else begin
            scratch_q     <= scratch_d;
            clk_en_q      <= clk_en_d;
            rst_active_q  <= rst_active_d;
            rst_cnt_q     <= rst_cnt_d;
            wdt_en_q      <= wdt_en_d;
            wdt_expired_q <= wdt_expired_d;
            wdt_load_q    <= wdt_load_d;
            wdt_count_q   <= wdt_count_d;
        end
    end

    assign reg_ready_o   = ready_q;
    assign reg_rdata_o   = rdata_q;
    assign reg_error_o   = error_q;
    assign tile_clk_en_o = clk_en_q;
    assign tile_rst_o    = rst_active_q;
    assign wdt_irq_o     = wdt_expired_q;

endmodule

// File: tb/tb_picobello_soc_ctrl.sv
// Self-checking bench for picobello_soc_ctrl: expected responses are queued
// when a request is issued and popped when the response handshake arrives.
module tb_picobello_soc_ctrl;
    localparam int NT = 16;
    localparam int RC = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          reg_valid = 1'b0;
    logic          reg_write = 1'b0;
    logic [31:0]   reg_addr = '0;
    logic [31:0]   reg_wdata = '0;
    logic [3:0]    reg_wstrb = '0;
    logic          reg_ready;
    logic [31:0]   reg_rdata;
    logic          reg_error;
    logic [NT-1:0] tile_clk_en;
    logic [NT-1:0] tile_rst;
    logic          wdt_irq;

    picobello_soc_ctrl #(.NumTiles(NT), .RstCycles(RC)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .reg_valid_i  (reg_valid),
        .reg_write_i  (reg_write),
        .reg_addr_i   (reg_addr),
        .reg_wdata_i  (reg_wdata),
        .reg_wstrb_i  (reg_wstrb),
        .reg_ready_o  (reg_ready),
        .reg_rdata_o  (reg_rdata),
        .reg_error_o  (reg_error),
        .tile_clk_en_o(tile_clk_en),
        .tile_rst_o   (tile_rst),
        .wdt_irq_o    (wdt_irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rd;
        logic        err;
        logic        chk;
    } acc_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] obs_rd;
    logic        obs_err;
    int          obs_lat;

    // Issue one access in an IDLE cycle and wait (bounded) for the response
    task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st);
        @(negedge clk);
        if (reg_ready) @(negedge clk);
        reg_valid = 1'b1;
        reg_write = wr;
        reg_addr  = addr;
        reg_wdata = wd;
        reg_wstrb = st;
        obs_lat   = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (reg_ready) begin
                obs_lat = i;
                break;
            end
        end
        obs_rd    = reg_rdata;
        obs_err   = reg_error;
        reg_valid = 1'b0;
        reg_write = 1'b0;
        $display("[TB] %s addr=%h wdata=%h strb=%b -> rdata=%h err=%b lat=%0d",
                 wr ? "WR" : "RD", addr, wd, st, obs_rd, obs_err, obs_lat);
    endtask

    task automatic test_reset();
        acc_t t [3];
        exp_t e;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (reg_ready !== 1'b0 || reg_rdata !== 32'd0 || reg_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus ready=%b rdata=%h err=%b, expected 0/0/0", reg_ready, reg_rdata, reg_error);
        end
        n_tests++;
        if (tile_clk_en !== 16'hFFFF || tile_rst !== 16'h0 || wdt_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs clk_en=%h rst=%h irq=%b, expected ffff/0000/0", tile_clk_en, tile_rst, wdt_irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        t = '{'{1'b0, 32'h10, 32'h0, 4'h0, 32'h0000FFFF, 1'b0, 1'b1},
              '{1'b0, 32'h14, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1},
              '{1'b0, 32'h24, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1}};
        foreach (t[i]) begin
            sb_q.push_back('{t[i].rd, t[i].err, t[i].chk});
            bus(t[i].wr, t[i].addr, t[i].wdata, t[i].strb);
            e = sb_q.pop_front();
            n_tests++;
            if (obs_lat !== 1 || obs_err !== e.err || (e.chk && obs_rd !== e.rd)) begin
                n_fail++;
                $display("FAIL reset_read[%0d] rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=1",
                         i, obs_rd, obs_err, obs_lat, e.rd, e.err);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (reg_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_one_cycle[%0d] ready=%b, expected 0", i, reg_ready);
            end
        end
    endtask

    task automatic test_scratch();
        acc_t t [2];
        exp_t e;
        t = '{'{1'b1, 32'h04, 32'hDEADBEEF, 4'b0101, 32'h0, 1'b0, 1'b0},
              '{1'b0, 32'h04, 32'h0, 4'h0, 32'h00AD00EF, 1'b0, 1'b1}};
        foreach (t[i]) begin
            sb_q.push_back('{t[i].rd, t[i].err, t[i].chk});
            bus(t[i].wr, t[i].addr, t[i].wdata, t[i].strb);
            e = sb_q.pop_front();
            n_tests++;
            if (obs_lat !== 1 || obs_err !== e.err || (e.chk && obs_rd !== e.rd)) begin
                n_fail++;
                $display("FAIL scratch[%0d] rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=1",
                         i, obs_rd, obs_err, obs_lat, e.rd, e.err);
            end
        end
    endtask

    task automatic test_tile_clk();
        acc_t t [4];
        exp_t e;
        logic [NT-1:0] exp_en [4];
        t = '{'{1'b1, 32'h10, 32'hFFFF1234, 4'b1111, 32'h0, 1'b0, 1'b0},
              '{1'b0, 32'h10, 32'h0, 4'h0, 32'h00001234, 1'b0, 1'b1},
              '{1'b1, 32'h10, 32'h00000000, 4'b0010, 32'h0, 1'b0, 1'b0},
              '{1'b0, 32'h10, 32'h0, 4'h0, 32'h00000034, 1'b0, 1'b1}};
        exp_en = '{16'h1234, 16'h1234, 16'h0034, 16'h0034};
        foreach (t[i]) begin
            sb_q.push_back('{t[i].rd, t[i].err, t[i].chk});
            bus(t[i].wr, t[i].addr, t[i].wdata, t[i].strb);
            e = sb_q.pop_front();
            n_tests++;
            if (obs_lat !== 1 || obs_err !== e.err || (e.chk && obs_rd !== e.rd)
                || tile_clk_en !== exp_en[i]) begin
                n_fail++;
                $display("FAIL tile_clk[%0d] rdata=%h err=%b lat=%0d clk_en=%h, expected rdata=%h err=%b clk_en=%h",
                         i, obs_rd, obs_err, obs_lat, tile_clk_en, e.rd, e.err, exp_en[i]);
            end
        end
    endtask

    task automatic test_tile_rst();
        exp_t e;
        bus(1'b1, 32'h14, 32'h0000_0005, 4'hF);
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (tile_rst !== 16'h0005) begin
                n_fail++;
                $display("FAIL pulse_a[%0d] tile_rst=%h, expected 0005", i, tile_rst);
            end
            @(posedge clk);
            #1;
        end
        bus(1'b1, 32'h14, 32'h0000_0002, 4'hF);
        for (int i = 0; i < RC; i++) begin
            n_tests++;
            if (tile_rst !== 16'h0007) begin
                n_fail++;
                $display("FAIL pulse_b[%0d] tile_rst=%h, expected 0007", i, tile_rst);
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (tile_rst !== 16'h0000) begin
            n_fail++;
            $display("FAIL pulse_end tile_rst=%h, expected 0000", tile_rst);
        end
        // zero and strobe-masked writes must not start a pulse
        bus(1'b1, 32'h14, 32'h0000_0000, 4'hF);
        bus(1'b1, 32'h14, 32'h0000_0300, 4'b0001);
        @(posedge clk);
        #1;
        n_tests++;
        if (tile_rst !== 16'h0000) begin
            n_fail++;
            $display("FAIL pulse_zero tile_rst=%h, expected 0000", tile_rst);
        end
        // read-back of the active set while a pulse runs
        bus(1'b1, 32'h14, 32'h0000_0008, 4'hF);
        sb_q.push_back('{32'h0000_0008, 1'b0, 1'b1});
        bus(1'b0, 32'h14, 32'h0, 4'h0);
        e = sb_q.pop_front();
        n_tests++;
        if (obs_lat !== 1 || obs_err !== e.err || obs_rd !== e.rd) begin
            n_fail++;
            $display("FAIL pulse_read rdata=%h err=%b lat=%0d, expected rdata=%h err=%b", obs_rd, obs_err, obs_lat, e.rd, e.err);
        end
        repeat (RC + 2) @(posedge clk);
        #1;
        n_tests++;
        if (tile_rst !== 16'h0000) begin
            n_fail++;
            $display("FAIL pulse_read_end tile_rst=%h, expected 0000", tile_rst);
        end
    endtask

    task automatic test_wdt();
        logic [31:0] exp_cnt [3];
        exp_t e;
        exp_cnt = '{32'd4, 32'd2, 32'd0};
        bus(1'b1, 32'h1C, 32'd5, 4'hF);
        bus(1'b1, 32'h18, 32'd1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                n_tests++;
                if (wdt_irq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wdt_irq_early irq=%b, expected 0", wdt_irq);
                end
                @(posedge clk);
                #1;
                n_tests++;
                if (wdt_irq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wdt_irq_cycle5 irq=%b, expected 0", wdt_irq);
                end
            end
            sb_q.push_back('{exp_cnt[i], 1'b0, 1'b1});
            bus(1'b0, 32'h20, 32'h0, 4'h0);
            e = sb_q.pop_front();
            n_tests++;
            if (obs_lat !== 1 || obs_err !== e.err || obs_rd !== e.rd) begin
                n_fail++;
                $display("FAIL wdt_count[%0d] rdata=%h err=%b lat=%0d, expected rdata=%h err=%b",
                         i, obs_rd, obs_err, obs_lat, e.rd, e.err);
            end
        end
        n_tests++;
        if (wdt_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL wdt_irq_cycle6 irq=%b, expected 1", wdt_irq);
        end
        bus(1'b1, 32'h18, 32'd0, 4'hF);
        bus(1'b1, 32'h24, 32'd1, 4'b0001);
        n_tests++;
        if (wdt_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL wdt_w1c_ack irq=%b, expected 0", wdt_irq);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (wdt_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL wdt_w1c_after irq=%b, expected 0", wdt_irq);
        end
        sb_q.push_back('{32'd0, 1'b0, 1'b1});
        bus(1'b0, 32'h24, 32'h0, 4'h0);
        e = sb_q.pop_front();
        n_tests++;
        if (obs_err !== e.err || obs_rd !== e.rd) begin
            n_fail++;
            $display("FAIL wdt_status_clear rdata=%h err=%b, expected rdata=%h err=%b", obs_rd, obs_err, e.rd, e.err);
        end
        // LOAD=0: expiry one cycle after the enabling reload
        bus(1'b1, 32'h1C, 32'd0, 4'hF);
        bus(1'b1, 32'h18, 32'd1, 4'hF);
        n_tests++;
        if (wdt_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL wdt_load0_reload irq=%b, expected 0", wdt_irq);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (wdt_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL wdt_load0_expire irq=%b, expected 1", wdt_irq);
        end
        bus(1'b1, 32'h18, 32'd0, 4'hF);
        bus(1'b1, 32'h24, 32'd1, 4'b0001);
        n_tests++;
        if (wdt_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL wdt_load0_clear irq=%b, expected 0", wdt_irq);
        end
    endtask

    task automatic test_wdt_kick();
        exp_t e;
        bus(1'b1, 32'h1C, 32'd3, 4'hF);
        bus(1'b1, 32'h18, 32'd1, 4'hF);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        // this kick lands on the edge where COUNT is 0
        bus(1'b1, 32'h18, 32'd3, 4'hF);
        n_tests++;
        if (wdt_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL kick_at_zero irq=%b, expected 0", wdt_irq);
        end
        sb_q.push_back('{32'd2, 1'b0, 1'b1});
        bus(1'b0, 32'h20, 32'h0, 4'h0);
        e = sb_q.pop_front();
        n_tests++;
        if (obs_err !== e.err || obs_rd !== e.rd) begin
            n_fail++;
            $display("FAIL kick_reload rdata=%h err=%b, expected rdata=%h err=%b", obs_rd, obs_err, e.rd, e.err);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (wdt_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL kick_expire irq=%b, expected 1", wdt_irq);
        end
        // W1C while the expiry condition still holds: set wins
        bus(1'b1, 32'h24, 32'd1, 4'b0001);
        n_tests++;
        if (wdt_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL w1c_vs_set irq=%b, expected 1", wdt_irq);
        end
        sb_q.push_back('{32'd1, 1'b0, 1'b1});
        bus(1'b0, 32'h24, 32'h0, 4'h0);
        e = sb_q.pop_front();
        n_tests++;
        if (obs_err !== e.err || obs_rd !== e.rd) begin
            n_fail++;
            $display("FAIL w1c_vs_set_status rdata=%h err=%b, expected rdata=%h err=%b", obs_rd, obs_err, e.rd, e.err);
        end
        // kick while expired: COUNT reloads and then holds
        bus(1'b1, 32'h18, 32'd3, 4'hF);
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{32'd3, 1'b0, 1'b1});
            bus(1'b0, 32'h20, 32'h0, 4'h0);
            e = sb_q.pop_front();
            n_tests++;
            if (obs_err !== e.err || obs_rd !== e.rd || wdt_irq !== 1'b1) begin
                n_fail++;
                $display("FAIL kick_expired[%0d] rdata=%h err=%b irq=%b, expected rdata=%h err=%b irq=1",
                         i, obs_rd, obs_err, wdt_irq, e.rd, e.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        acc_t t [7];
        exp_t e;
        int   prev_cyc;
        t = '{'{1'b1, 32'h00, 32'h11111111, 4'hF, 32'h0, 1'b0, 1'b0},
              '{1'b1, 32'hABCD0008, 32'h22222222, 4'hF, 32'h0, 1'b0, 1'b0},
              '{1'b1, 32'h0C, 32'h33333333, 4'hF, 32'h0, 1'b0, 1'b0},
              '{1'b0, 32'h00, 32'h0, 4'h0, 32'h11111111, 1'b0, 1'b1},
              '{1'b0, 32'h80000004, 32'h0, 4'h0, 32'h00AD00EF, 1'b0, 1'b1},
              '{1'b0, 32'h08, 32'h0, 4'h0, 32'h22222222, 1'b0, 1'b1},
              '{1'b0, 32'hFFFFFFCC, 32'h0, 4'h0, 32'h33333333, 1'b0, 1'b1}};
        prev_cyc = 0;
        foreach (t[i]) begin
            sb_q.push_back('{t[i].rd, t[i].err, t[i].chk});
            bus(t[i].wr, t[i].addr, t[i].wdata, t[i].strb);
            e = sb_q.pop_front();
            n_tests++;
            if (obs_lat !== 1 || obs_err !== e.err || (e.chk && obs_rd !== e.rd)
                || (i > 0 && cyc - prev_cyc != 2)) begin
                n_fail++;
                $display("FAIL b2b[%0d] rdata=%h err=%b lat=%0d gap=%0d, expected rdata=%h err=%b gap=2",
                         i, obs_rd, obs_err, obs_lat, cyc - prev_cyc, e.rd, e.err);
            end
            prev_cyc = cyc;
        end
    endtask

    task automatic test_errors();
        acc_t t [7];
        exp_t e;
        t = '{'{1'b1, 32'h20, 32'h00001234, 4'hF, 32'h0, 1'b1, 1'b0},
              '{1'b0, 32'h20, 32'h0, 4'h0, 32'd3, 1'b0, 1'b1},
              '{1'b0, 32'h02, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1},
              '{1'b0, 32'h28, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1},
              '{1'b0, 32'h3C, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1},
              '{1'b1, 32'h06, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b0},
              '{1'b0, 32'h04, 32'h0, 4'h0, 32'h00AD00EF, 1'b0, 1'b1}};
        foreach (t[i]) begin
            sb_q.push_back('{t[i].rd, t[i].err, t[i].chk});
            bus(t[i].wr, t[i].addr, t[i].wdata, t[i].strb);
            e = sb_q.pop_front();
            n_tests++;
            if (obs_lat !== 1 || obs_err !== e.err || (e.chk && obs_rd !== e.rd)) begin
                n_fail++;
                $display("FAIL error[%0d] rdata=%h err=%b lat=%0d, expected rdata=%h err=%b",
                         i, obs_rd, obs_err, obs_lat, e.rd, e.err);
            end
        end
    endtask

    task automatic test_async_reset();
        acc_t t [3];
        exp_t e;
        bus(1'b1, 32'h14, 32'h0000_0003, 4'hF);
        n_tests++;
        if (tile_rst !== 16'h0003 || wdt_irq !== 1'b1 || tile_clk_en !== 16'h0034) begin
            n_fail++;
            $display("FAIL pre_reset tile_rst=%h irq=%b clk_en=%h, expected 0003/1/0034", tile_rst, wdt_irq, tile_clk_en);
        end
        bus(1'b0, 32'h04, 32'h0, 4'h0);
        n_tests++;
        if (obs_lat !== 1 || reg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_ack ready=%b lat=%0d, expected 1/1", reg_ready, obs_lat);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (reg_ready !== 1'b0 || reg_rdata !== 32'd0 || tile_rst !== 16'h0
            || tile_clk_en !== 16'hFFFF || wdt_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset ready=%b rdata=%h rst=%h clk_en=%h irq=%b, expected 0/0/0000/ffff/0",
                     reg_ready, reg_rdata, tile_rst, tile_clk_en, wdt_irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        t = '{'{1'b0, 32'h10, 32'h0, 4'h0, 32'h0000FFFF, 1'b0, 1'b1},
              '{1'b0, 32'h24, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1},
              '{1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1}};
        foreach (t[i]) begin
            sb_q.push_back('{t[i].rd, t[i].err, t[i].chk});
            bus(t[i].wr, t[i].addr, t[i].wdata, t[i].strb);
            e = sb_q.pop_front();
            n_tests++;
            if (obs_lat !== 1 || obs_err !== e.err || (e.chk && obs_rd !== e.rd)) begin
                n_fail++;
                $display("FAIL post_reset[%0d] rdata=%h err=%b lat=%0d, expected rdata=%h err=%b",
                         i, obs_rd, obs_err, obs_lat, e.rd, e.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_tile_clk();
        test_tile_rst();
        test_wdt();
        test_wdt_kick();
        test_back_to_back();
        test_errors();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t, expected completion before 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
